dfp_line_memory: RTL and testbench

- Memory-side responder for the cache downward-facing port (dfp): the other end of the dfp_addr/dfp_read/dfp_write/dfp_rdata/dfp_wdata/dfp_resp protocol.
- Serves one 256-bit line transaction at a time with a fixed, parameterised latency.
- Backed by an internal line store.
- Used as the main-memory model under the mutative cache in block and system benches. Also flags dfp protocol violations.

---
 rtl/dfp_line_memory.sv | 155 +++++++++++++++
 tb/tb_dfp_line_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_line_memory.sv
// Main-memory responder for the cache dfp port. It holds 2**DEPTH_BITS 256-bit lines and checks the dfp handshake.
// Latency: dfp_resp rises LATENCY cycles after the first IDLE cycle that sees a request. It serves one line at a time.
// Backpressure: none. The requester holds dfp_read or dfp_write until dfp_resp. Requests still up in RESP are ignored.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   dfp_addr/read/write/wdata   request from the cache, held until dfp_resp
//   dfp_rdata, dfp_resp         read line (valid in the resp cycle) and the one-cycle completion pulse
//   busy                        a transaction is in flight
//   protocol_err                sticky flag for handshake violations
//   rd_count, wr_count          completed reads and writes (these wrap)
module dfp_line_memory #(
    parameter int LATENCY     = 10,  // 1..255
    parameter int DEPTH_BITS  = 6,
    parameter int OFFSET_BITS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic         busy,
    output logic         protocol_err,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam int LINES = 1 << DEPTH_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [7:0]   cnt;
    logic [31:0]  lat_addr;
    logic         lat_rd;
    logic         lat_wr;
    logic [255:0] lat_wdata;

    logic [255:0]     mem [LINES];
    logic [LINES-1:0] line_vld;

    logic                  req;
    logic [31:0]           cur_addr;
    logic                  cur_wr;
    logic [DEPTH_BITS-1:0] cur_idx;
    logic [DEPTH_BITS-1:0] lat_idx;
    logic [31:0]           cur_aligned;
    logic [255:0]          cur_line;
    logic                  err_now;

    assign req = dfp_read | dfp_write;

    // With LATENCY=1, IDLE goes straight to RESP. The latches are not loaded yet at that edge.
    // So the rdata load must look at the live inputs while the FSM is in IDLE.
    assign cur_addr    = (state == IDLE) ? dfp_addr  : lat_addr;
    assign cur_wr      = (state == IDLE) ? dfp_write : lat_wr;
    assign cur_idx     = cur_addr[OFFSET_BITS+DEPTH_BITS-1:OFFSET_BITS];
    assign lat_idx     = lat_addr[OFFSET_BITS+DEPTH_BITS-1:OFFSET_BITS];
    assign cur_aligned = {cur_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // A line that was never written returns its own aligned address, repeated 8 times.
    assign cur_line = line_vld[cur_idx] ? mem[cur_idx] : {8{cur_aligned}};

    // Violations. In IDLE the checks are read+write together and a non-aligned address.
    // While busy, the live request must match the latched copy. A dropped request also fails this.
    always_comb begin
        err_now = 1'b0;
        if (state == IDLE) begin
            if (dfp_read && dfp_write)
                err_now = 1'b1;
            if (req && (dfp_addr[OFFSET_BITS-1:0] != '0))
                err_now = 1'b1;
        end else begin
            if ((dfp_addr != lat_addr) || (dfp_read != lat_rd) || (dfp_write != lat_wr))
                err_now = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        dfp_resp  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req)
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt <= 8'd1)
                    state_nxt = RESP;
            end
            RESP: begin
                dfp_resp  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            lat_addr     <= 32'd0;
            lat_rd       <= 1'b0;
            lat_wr       <= 1'b0;
            lat_wdata    <= '0;
            line_vld     <= '0;
            dfp_rdata    <= '0;
            protocol_err <= 1'b0;
            rd_count     <= 32'd0;
            wr_count     <= 32'd0;
        end else begin
            state <= state_nxt;

            if (err_now)
                protocol_err <= 1'b1;

            if (state == IDLE && req) begin
                lat_addr  <= dfp_addr;
                lat_rd    <= dfp_read;
                lat_wr    <= dfp_write;   // read+write together is served as a write
                lat_wdata <= dfp_wdata;
                cnt       <= 8'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end

            // Load the read data on the edge that enters RESP, so it is valid during the resp cycle.
            if (state != RESP && state_nxt == RESP && !cur_wr)
                dfp_rdata <= cur_line;

            if (state == RESP) begin
                if (lat_wr) begin
                    line_vld[lat_idx] <= 1'b1;
                    wr_count          <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
        end
    end

    // Line data has no reset. After a reset, the cleared valid bits hide any stale contents.
    always_ff @(posedge clk) begin
        if (state == RESP && lat_wr)
            mem[lat_idx] <= lat_wdata;
    end

endmodule

// File: tb/tb_dfp_line_memory.sv
module tb_dfp_line_memory;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         busy;
    logic         protocol_err;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    dfp_line_memory #(.LATENCY(10), .DEPTH_BITS(6), .OFFSET_BITS(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .dfp_addr     (dfp_addr),
        .dfp_read     (dfp_read),
        .dfp_write    (dfp_write),
        .dfp_wdata    (dfp_wdata),
        .dfp_rdata    (dfp_rdata),
        .dfp_resp     (dfp_resp),
        .busy         (busy),
        .protocol_err (protocol_err),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_addr  = 32'd0;
        dfp_wdata = '0;
        step;
        step;
        rst = 1'b0;
        step;
    endtask

    // Move to the next cycle, drive a request, then hold it until dfp_resp or a 40-cycle bound.
    // The task returns inside the resp cycle with the request still driven.
    task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [255:0] d, output int lat);
        step;
        dfp_read  = rd;
        dfp_write = wr;
        dfp_addr  = a;
        dfp_wdata = d;
        lat = 0;
        while (lat < 40) begin
            step;
            lat++;
            if (dfp_resp) break;
        end
    endtask

    task automatic idle;
        step;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t1;
        int t2;
        int seen;
        logic [255:0] a5;
        logic [255:0] d1;
        logic [255:0] d2;
        logic [255:0] d3;
        logic [255:0] d4;
        a5 = {32{8'hA5}};
        d1 = {4{64'h0123_4567_89AB_CDEF}};
        d2 = {8{32'hCAFE_F00D}};
        d3 = {16{16'h3C5A}};
        d4 = {8{32'h1357_9BDF}};

        // Reset state, then one read of 0x120 held from cycle 0.
        do_reset;
        chk("reset_rdata", dfp_rdata, 256'd0);
        chk("reset_resp", dfp_resp, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", protocol_err, 0);
        chk("reset_rd_count", rd_count, 0);
        chk("reset_wr_count", wr_count, 0);
        dfp_read = 1'b1;
        dfp_addr = 32'h0000_0120;
        chk("rd_c0_resp", dfp_resp, 0);
        chk("rd_c0_busy", busy, 0);
        for (int i = 1; i <= 10; i++) begin
            step;
            chk($sformatf("rd_c%0d_busy", i), busy, 1);
            chk($sformatf("rd_c%0d_resp", i), dfp_resp, (i == 10) ? 1 : 0);
        end
        chk("rd_default_rdata", dfp_rdata, {8{32'h0000_0120}});
        idle;
        chk("rd_count_1", rd_count, 1);
        chk("rd_after_busy", busy, 0);
        chk("rd_after_resp", dfp_resp, 0);
        chk("rd_rdata_hold", dfp_rdata, {8{32'h0000_0120}});

        // Read-after-write to 0x40.
        do_reset;
        run(1'b0, 1'b1, 32'h0000_0040, a5, lat);
        chk("raw_wr_lat", lat, 10);
        run(1'b1, 1'b0, 32'h0000_0040, '0, lat);
        chk("raw_rd_lat", lat, 10);
        chk("raw_rdata", dfp_rdata, a5);
        idle;
        chk("raw_wr_count", wr_count, 1);
        chk("raw_rd_count", rd_count, 1);

        // A writeback to the aliased address, then an immediate refill.
        do_reset;
        run(1'b0, 1'b1, 32'h1000_0040, d1, lat);
        t1 = cyc;
        run(1'b1, 1'b0, 32'h0000_0040, '0, lat);
        t2 = cyc;
        chk("alias_resp_gap", t2 - t1, 11);
        chk("alias_rdata", dfp_rdata, d1);
        chk("alias_no_err", protocol_err, 0);
        idle;

        // Read and write together at 0x84: this is an error and is served as a write to index 4.
        do_reset;
        run(1'b1, 1'b1, 32'h0000_0084, d2, lat);
        chk("both_lat", lat, 10);
        chk("both_err", protocol_err, 1);
        run(1'b1, 1'b0, 32'h0000_0080, '0, lat);
        chk("both_rdata_idx4", dfp_rdata, d2);
        chk("both_err_sticky", protocol_err, 1);
        idle;
        chk("both_wr_count", wr_count, 1);
        chk("both_rd_count", rd_count, 1);

        // The address changes in cycle 3 of a read. The latched 0x100 (index 8) is still served.
        do_reset;
        run(1'b0, 1'b1, 32'h0000_0100, d3, lat);
        chk("chg_pre_err", protocol_err, 0);
        step;
        dfp_read  = 1'b1;
        dfp_write = 1'b0;
        dfp_addr  = 32'h0000_0100;
        step;
        step;
        step;
        chk("chg_c3_err", protocol_err, 0);
        dfp_addr = 32'h0000_0200;
        lat = 3;
        while (lat < 40) begin
            step;
            lat++;
            if (dfp_resp) break;
        end
        chk("chg_lat", lat, 10);
        chk("chg_err", protocol_err, 1);
        chk("chg_rdata", dfp_rdata, d3);
        idle;

        // Reset arrives in cycle 5 of a write to 0x60. The write is dropped and no resp appears.
        do_reset;
        step;
        dfp_write = 1'b1;
        dfp_addr  = 32'h0000_0060;
        dfp_wdata = d4;
        repeat (5) step;
        chk("rstmid_busy_before", busy, 1);
        rst       = 1'b1;
        dfp_write = 1'b0;
        #1;
        chk("rstmid_busy_async", busy, 0);
        step;
        step;
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            step;
            if (dfp_resp) seen++;
        end
        chk("rstmid_no_resp", seen, 0);
        chk("rstmid_wr_count", wr_count, 0);
        chk("rstmid_rd_count", rd_count, 0);
        run(1'b1, 1'b0, 32'h0000_0060, '0, lat);
        chk("rstmid_rd_lat", lat, 10);
        chk("rstmid_rdata_default", dfp_rdata, {8{32'h0000_0060}});
        idle;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
